// File: rtl/rsa_pkg.sv
// rsa_pkg -- constants shared by the RSA exponentiation datapath.
//   DEF_WIDTH / DEF_CNT_W : default operand width and product-unit count width
//   ST_*                  : exponentiator FSM state encoding (3-bit)
//   clog2()               : ceiling log2, usable in parameter defaults
package rsa_pkg;

   localparam int DEF_WIDTH = 1024;
   localparam int DEF_CNT_W = 10;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SQR  = 3'd1;
   localparam logic [2:0] ST_MUL  = 3'd2;
   localparam logic [2:0] ST_CONV = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/mon_exp_engine_if.sv
// mon_exp_engine_if -- request/response bundle between the RSA controller
// (master) and the Montgomery exponentiator (slave).
//   start, M_bar, x_bar, e, e_idx, n, mp_count : controller -> engine
//   busy, done, ans                             : engine -> controller
interface mon_exp_engine_if import rsa_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDX_W = clog2(WIDTH),
   parameter int CNT_W = DEF_CNT_W
);
   logic             start;
   logic [WIDTH-1:0] M_bar;
   logic [WIDTH-1:0] x_bar;
   logic [WIDTH-1:0] e;
   logic [IDX_W-1:0] e_idx;
   logic [WIDTH-1:0] n;
   logic [CNT_W-1:0] mp_count;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] ans;

   modport master (output start, M_bar, x_bar, e, e_idx, n, mp_count,
                   input  busy, done, ans);
   modport slave  (input  start, M_bar, x_bar, e, e_idx, n, mp_count,
                   output busy, done, ans);
endinterface

// File: rtl/mon_prod_p.sv
// mon_prod_p -- bit-serial (radix-2) Montgomery product P = A*B*2^-(mp_count+1) mod M.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : one-cycle request; A is latched, B and M must stay stable
//   A, B, M       : operands (A, B < M, M odd)
//   mp_count      : number of iterations minus one (WIDTH-1 for R = 2^WIDTH)
//   stop          : rises once when P is valid, falls on the next start
//   P             : fully reduced product, held until the next completion
module mon_prod_p import rsa_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] M,
   input  logic [CNT_W-1:0] mp_count,
   output logic             stop,
   output logic [WIDTH-1:0] P
);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Two guard bits: the running sum stays below 2M, so S + B + M < 4M.
   logic [WIDTH+1:0] s_q, s_d, sum_ab, sum_abm;
   logic [WIDTH-1:0] a_q, p_q, p_d;
   logic [CNT_W-1:0] cnt_q;
   logic             run_q, stop_q;

   always_comb begin
      sum_ab  = s_q + (a_q[0] ? {2'b00, B} : '0);
      sum_abm = sum_ab[0] ? sum_ab + {2'b00, M} : sum_ab;
      s_d     = sum_abm >> 1;
      // s_d < 2M, so one conditional subtraction fully reduces it; the
      // difference is below M and therefore fits in WIDTH bits.
      p_d     = (s_d >= {2'b00, M}) ? s_d[WIDTH-1:0] - M : s_d[WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q    <= '0;
         a_q    <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         stop_q <= 1'b0;
         p_q    <= '0;
      end else if (start) begin
         s_q    <= '0;
         a_q    <= A;
         cnt_q  <= '0;
         run_q  <= 1'b1;
         stop_q <= 1'b0;
      end else if (run_q) begin
         s_q   <= s_d;
         a_q   <= a_q >> 1;
         cnt_q <= cnt_q + CNT_ONE;
         if (cnt_q == mp_count) begin
            run_q  <= 1'b0;
            stop_q <= 1'b1;
            p_q    <= p_d;
         end
      end
   end

   assign stop = stop_q;
   assign P    = p_q;
endmodule

// File: rtl/mon_exp_engine.sv
// mon_exp_engine -- left-to-right square-and-multiply modular exponentiator
// over Montgomery-domain operands, finishing with a conversion MP(acc,1).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of mon_exp_engine_if (start/operands in,
//              busy/done/ans out); ans = M^e mod n in the normal domain
module mon_exp_engine import rsa_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDX_W = clog2(WIDTH),
   parameter int CNT_W = DEF_CNT_W
) (
   input logic             clk,
   input logic             rst,
   mon_exp_engine_if.slave bus
);
   localparam logic [WIDTH-1:0] W_ONE   = WIDTH'(1);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d, m_bar_q, m_bar_d, e_q, e_d, n_q, n_d;
   logic [WIDTH-1:0] mp_a_q, mp_a_d, mp_b_q, mp_b_d, ans_q, ans_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             mp_start_q, mp_start_d, pending_q, pending_d;
   logic             busy_q, busy_d, done_q, done_d, stop_q;
   logic             mp_stop, stop_edge;
   logic [WIDTH-1:0] mp_p;

   // Completion is the rising edge of stop; an edge with nothing pending
   // (e.g. left over from an abandoned run) is ignored.
   assign stop_edge = mp_stop & ~stop_q;

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      m_bar_d    = m_bar_q;
      e_d        = e_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      mp_a_d     = mp_a_q;
      mp_b_d     = mp_b_q;
      mp_start_d = 1'b0;
      pending_d  = pending_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ans_d      = ans_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               m_bar_d = bus.M_bar;
               e_d     = bus.e;
               n_d     = bus.n;
               cnt_d   = bus.mp_count;
               acc_d   = bus.x_bar;
               idx_d   = bus.e_idx;
               busy_d  = 1'b1;
               state_d = ST_SQR;
            end
         end
         ST_SQR, ST_MUL, ST_CONV: begin
            if (!pending_q) begin
               mp_start_d = 1'b1;
               pending_d  = 1'b1;
               mp_a_d     = (state_q == ST_MUL)  ? m_bar_q : acc_q;
               mp_b_d     = (state_q == ST_CONV) ? W_ONE   : acc_q;
            end else if (stop_edge) begin
               pending_d = 1'b0;
               if (state_q == ST_CONV) begin
                  ans_d   = mp_p;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  acc_d = mp_p;
                  // The idx=0 test comes before the decrement, so idx never wraps.
                  if (state_q == ST_SQR && e_q[idx_q]) begin
                     state_d = ST_MUL;
                  end else if (idx_q == '0) begin
                     state_d = ST_CONV;
                  end else begin
                     idx_d   = idx_q - IDX_ONE;
                     state_d = ST_SQR;
                  end
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         acc_q      <= '0;
         m_bar_q    <= '0;
         e_q        <= '0;
         n_q        <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         mp_a_q     <= '0;
         mp_b_q     <= '0;
         mp_start_q <= 1'b0;
         pending_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ans_q      <= '0;
         stop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         m_bar_q    <= m_bar_d;
         e_q        <= e_d;
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         mp_a_q     <= mp_a_d;
         mp_b_q     <= mp_b_d;
         mp_start_q <= mp_start_d;
         pending_q  <= pending_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ans_q      <= ans_d;
         stop_q     <= mp_stop;
      end
   end

   mon_prod_p #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_prod (
      .clk      (clk),
      .rst      (rst),
      .start    (mp_start_q),
      .A        (mp_a_q),
      .B        (mp_b_q),
      .M        (n_q),
      .mp_count (cnt_q),
      .stop     (mp_stop),
      .P        (mp_p)
   );

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.ans  = ans_q;
endmodule

// File: doc/mon_exp_engine.md
Name: mon_exp_engine

Overview:
- Parametrised successor to the fixed-1024-bit Montgomery exponentiator.
- Computes ans = M^e mod n using left-to-right square-and-multiply over the Montgomery-domain inputs M_bar and x_bar.
- Adds what the previous generation lacked: a final conversion out of the Montgomery domain (MP(acc,1)), asynchronous reset, capture of all operands at start, and a busy/done handshake.
- Sits between the RSA top-level controller and a single Montgomery-product unit.

Parameters:
- WIDTH, 1024, operand/modulus width in bits; R = 2^WIDTH.
- IDX_W, $clog2(WIDTH), width of the exponent MSB index.
- CNT_W, 10, width of the mp_count iteration count forwarded to the product unit.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- M_bar  in  WIDTH  message in Montgomery form (M·R mod n).
- x_bar  in  WIDTH  Montgomery one (R mod n), initial accumulator.
- e  in  WIDTH  exponent.
- e_idx  in  IDX_W  index of the highest exponent bit to process.
- n  in  WIDTH  odd modulus.
- mp_count  in  CNT_W  product-unit iteration count, passed through.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse when ans is valid.
- ans  out  WIDTH  result M^e mod n, normal domain; held until the next start.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, ans=0, acc=0, pending=0, product start=0. Any operation in flight is abandoned.
- Start acceptance: in IDLE with start=1, register M_bar, e, n, mp_count; acc<=x_bar; idx<=e_idx; busy<=1; go to SQR and issue a square.
  - start while busy is ignored.
  - Inputs may change freely after acceptance.
- Product handshake:
  - Engine drives the product start high for exactly one cycle with A, B, M held stable until completion, and sets pending=1.
  - Completion is the rising edge of the product stop, detected with a registered copy of stop.
  - Stop edges seen while pending=0 are ignored; this covers stale stops after reset.
- States and transitions:
  - IDLE: wait for start.
  - SQR: issue MP(acc,acc). On completion, acc<=P. If e_r[idx]=1, go to MUL. Else if idx=0, go to CONV. Else idx<=idx-1 and stay in SQR.
  - MUL: issue MP(M_bar_r,acc). On completion, acc<=P. If idx=0, go to CONV. Else idx<=idx-1 and go to SQR.
  - CONV: issue MP(acc,1). On completion, ans<=P, go to DONE.
  - DONE: done=1 for one cycle, busy<=0, go to IDLE.
- Product count: exactly (e_idx+1) squares + popcount(e_r[e_idx:0]) multiplies + 1 conversion. Engine overhead is at most 2 cycles per product plus 1 cycle for DONE.
- Boundaries:
  - e_idx=0 runs one square, an optional multiply, then the conversion.
  - e=0 yields ans=1 when x_bar = R mod n.
  - Bits of e above e_idx are ignored.
  - idx never wraps; the idx=0 test precedes the decrement.
  - start asserted in the DONE cycle is ignored; it is accepted from IDLE on the following cycle.
  - Even n is out of contract and the result is undefined, but the FSM must still terminate.

Decomposition:
- Shared package rsa_pkg holds:
  - state encoding constants (IDLE, SQR, MUL, CONV, DONE, 3-bit);
  - the default WIDTH/CNT_W;
  - a function for clog2.
- One sub-module: mon_prod_p, a WIDTH-parametrised Montgomery product (clk, rst, start, A, B, M, mp_count, stop, P).
  - Same contract as the existing product unit.
  - stop rises once per start and falls on the next start.

Test Plan:
1. WIDTH=8, n=13, M_bar=6, x_bar=9, e=3, e_idx=1, start pulse -> exactly 5 products (S,M,S,M,C), done pulse once, ans=8, busy low the same cycle done is high.
2. Same operands, e=0, e_idx=0 -> 2 products (S,C), ans=1.
3. Same operands, e=0b10, e_idx=1 -> 4 products (S,M,S,C), ans=25 mod 13=12. Repeat with e=0xF2, e_idx=1 -> identical result, proving bits above e_idx are ignored.
4. Change M_bar, e and n in the cycle after acceptance, and pulse start again mid-run -> ans still 8 as in scenario 1, only one done pulse.
5. Assert rst during the third product -> outputs at reset values immediately. A fresh start of scenario 1 then completes with ans=8, and no spurious done from the abandoned product's stop.
6. WIDTH=1024 random 1024-bit odd n, random e with e_idx=1023 -> ans matches the reference-model modexp; product count equals 1024 + popcount(e) + 1.
